fetch_queue: RTL



---
 rtl/fetch_queue.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// mmm_pkg    : shared width constants (XLEN, ILEN).
// fetch_queue: fetch stage between PC generation and the i-cache.
//
// Every accepted i-cache request reserves a slot in a DEPTH-entry in-order
// queue. The slot holds the request's PC and branch prediction until the
// i-cache response fills in the instruction. Decode issues from the queue
// head. A flush empties the queue and arms a drop counter. The counter
// discards the responses that are still in flight when the flush occurs.
//
// Compile-time option:
//   FETCH_QUEUE_BYPASS_EN - when the queue is empty, a non-dropped response
//                           is presented to decode in the cycle it arrives.
//
// Parameters:
//   DEPTH           queue entries (power of two, >= 2)
//   MAX_OUTSTANDING i-cache requests in flight, dropped ones included
//
// Ports:
//   clk_i, rst_n_i           clock, async active-low reset
//   flush_i                  one-cycle synchronous flush
//   pc_i, pc_valid_i         fetch PC from PC generation
//   pred_taken_i/target_i    BPU prediction for pc_i
//   pc_ready_o               request accepted this cycle
//   addr_o/valid_o/ready_i   i-cache request channel
//   data_i/valid_i/ready_o   i-cache response channel (in request order)
//   issue_*/instruction_o,   head entry towards decode
//   pc_o, pred_*_o
//   count_o                  filled entries
// ---------------------------------------------------------------------------
package mmm_pkg;
  parameter int unsigned XLEN = 32;
  parameter int unsigned ILEN = 32;
endpackage

module fetch_queue
  import mmm_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      flush_i,
  input  logic [XLEN-1:0]           pc_i,
  input  logic                      pc_valid_i,
  input  logic                      pred_taken_i,
  input  logic [XLEN-1:0]           pred_target_i,
  output logic                      pc_ready_o,
  output logic [XLEN-1:0]           addr_o,
  output logic                      addr_valid_o,
  input  logic                      addr_ready_i,
  input  logic [ILEN-1:0]           data_i,
  input  logic                      data_valid_i,
  output logic                      data_ready_o,
  input  logic                      issue_ready_i,
  output logic                      issue_valid_o,
  output logic [ILEN-1:0]           instruction_o,
  output logic [XLEN-1:0]           pc_o,
  output logic                      pred_taken_o,
  output logic [XLEN-1:0]           pred_target_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;                      // index + wrap bit
  localparam int unsigned DW = $clog2(MAX_OUTSTANDING + 1);

  // head: next entry to issue; fill: next entry to receive data;
  // alloc: next slot to reserve. head <= fill <= alloc (modulo 2*DEPTH).
  logic [PW-1:0]   r_head, r_fill, r_alloc;
  logic [DW-1:0]   r_drop_cnt;

  logic [XLEN-1:0] r_pc_mem     [DEPTH];
  logic            r_taken_mem  [DEPTH];
  logic [XLEN-1:0] r_target_mem [DEPTH];
  logic [ILEN-1:0] r_instr_mem  [DEPTH];

  logic [PW-1:0]   w_used;
  logic [PW-1:0]   w_pending;
  logic [PW:0]     w_inflight;
  logic            w_credit;
  logic            w_req;
  logic            w_fill_rsp;
  logic            w_drop_rsp;
  logic            w_bypass;
  logic            w_issue;
  logic [AW-1:0]   w_head_idx;

  assign w_head_idx = r_head[AW-1:0];

  // Reserved slots count against the queue even before their data arrives.
  assign w_used     = r_alloc - r_head;
  assign w_pending  = r_alloc - r_fill;
  assign w_inflight = {1'b0, w_pending} + (PW+1)'(r_drop_cnt);

  assign w_credit     = (w_used < PW'(DEPTH))
                      & (w_inflight < (PW+1)'(MAX_OUTSTANDING))
                      & ~flush_i;
  assign addr_valid_o = pc_valid_i & w_credit;
  assign addr_o       = pc_i;
  assign w_req        = addr_valid_o & addr_ready_i;
  assign pc_ready_o   = w_req;

  // Responses are always accepted: every one of them already owns a slot
  // or is counted in the drop counter.
  assign data_ready_o = 1'b1;
  assign w_drop_rsp   = data_valid_i & (r_drop_cnt != '0);
  assign w_fill_rsp   = data_valid_i & (r_drop_cnt == '0) & ~flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue with a live response: forward it straight to decode.
  assign w_bypass = (r_fill == r_head) & w_fill_rsp;
`else
  assign w_bypass = 1'b0;
`endif

  assign issue_valid_o = ((r_fill != r_head) | w_bypass) & ~flush_i;
  assign w_issue       = issue_valid_o & issue_ready_i;
  assign instruction_o = w_bypass ? data_i : r_instr_mem[w_head_idx];
  assign pc_o          = r_pc_mem[w_head_idx];
  assign pred_taken_o  = r_taken_mem[w_head_idx];
  assign pred_target_o = r_target_mem[w_head_idx];
  assign count_o       = r_fill - r_head;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_head     <= '0;
      r_fill     <= '0;
      r_alloc    <= '0;
      r_drop_cnt <= '0;
    end else if (flush_i) begin
      // Everything reserved or in flight is abandoned. The drop counter
      // absorbs all outstanding responses, except one that arrives in
      // this very cycle, which is discarded here.
      r_head     <= r_alloc;
      r_fill     <= r_alloc;
      r_drop_cnt <= DW'(w_inflight - (PW+1)'(data_valid_i));
    end else begin
      if (w_req)      r_alloc    <= r_alloc + PW'(1);
      if (w_fill_rsp) r_fill     <= r_fill + PW'(1);
      if (w_issue)    r_head     <= r_head + PW'(1);
      if (w_drop_rsp) r_drop_cnt <= r_drop_cnt - DW'(1);
    end
  end

  // NOTE: the entry storage has no reset. An entry is only read between
  // head and fill, and it has always been written before it gets there.
  always_ff @(posedge clk_i) begin
    if (w_req) begin
      r_pc_mem[r_alloc[AW-1:0]]     <= pc_i;
      r_taken_mem[r_alloc[AW-1:0]]  <= pred_taken_i;
      r_target_mem[r_alloc[AW-1:0]] <= pred_target_i;
    end
    if (w_fill_rsp) r_instr_mem[r_fill[AW-1:0]] <= data_i;
  end

endmodule
